// File: rtl/squash_row_ctrl.sv
// Row sequencer for the 1-D lifting "squash" transform: reads one row from a
// 1-cycle-latency line memory and writes L to the lower half, H to the upper half.
module squash_row_ctrl #(
    parameter int ROW_LEN = 16,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W-1:0] M_A    = ADDR_W'(ROW_LEN / 2);
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(ROW_LEN / 2 - 1);

    typedef enum logic [2:0] {
        IDLE, RD0, RD_O, RD_E, CALC, WR_H, WR_L, DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] k_inc;
    logic              last_pair;
    logic [DATA_W-1:0] x_even, x_odd, x_next, h_cur, h_prev;
    logic [DATA_W-1:0] xn_sel;

    // Held copies so address/data stay stable while their strobe is low
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              rd_en_c, wr_en_c, done_c;
    logic [ADDR_W-1:0] rd_addr_c, wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;

    // H = x_odd - ((x_even + x_next) >> 1); the sum keeps its carry bit
    function automatic logic [DATA_W-1:0] predict(input logic [DATA_W-1:0] xo,
                                                  input logic [DATA_W-1:0] xe,
                                                  input logic [DATA_W-1:0] xn);
        logic [DATA_W:0] s;
        s = {1'b0, xe} + {1'b0, xn};
        return xo - s[DATA_W:1];
    endfunction

    // L = x_even + ((h_left + h_right) >> 2), wrapping mod 2^DATA_W
    function automatic logic [DATA_W-1:0] update(input logic [DATA_W-1:0] xe,
                                                 input logic [DATA_W-1:0] hl,
                                                 input logic [DATA_W-1:0] hr);
        logic [DATA_W:0] s;
        s = {1'b0, hl} + {1'b0, hr};
        return xe + {1'b0, s[DATA_W:2]};
    endfunction

    assign k_inc     = k + ADDR_W'(1);
    assign last_pair = (k == K_LAST);
    // Right-edge symmetric extension: x[ROW_LEN] mirrors x[ROW_LEN-2]
    assign xn_sel    = last_pair ? x_even : rd_data;

    always_comb begin
        state_nx  = state;
        rd_en_c   = 1'b0;
        rd_addr_c = rd_addr_q;
        wr_en_c   = 1'b0;
        wr_addr_c = wr_addr_q;
        wr_data_c = wr_data_q;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RD0;
            end
            RD0: begin
                rd_en_c   = 1'b1;
                rd_addr_c = '0;
                state_nx  = RD_O;
            end
            RD_O: begin
                rd_en_c   = 1'b1;
                rd_addr_c = {k[ADDR_W-2:0], 1'b1};
                state_nx  = RD_E;
            end
            RD_E: begin
                if (!last_pair) begin
                    rd_en_c   = 1'b1;
                    rd_addr_c = {k_inc[ADDR_W-2:0], 1'b0};
                end
                state_nx = CALC;
            end
            CALC: begin
                state_nx = WR_H;
            end
            WR_H: begin
                wr_en_c   = 1'b1;
                wr_addr_c = M_A + k;
                wr_data_c = h_cur;
                state_nx  = WR_L;
            end
            WR_L: begin
                wr_en_c   = 1'b1;
                wr_addr_c = k;
                // Left-edge extension: H[-1] = H[0]
                wr_data_c = update(x_even, (k == '0) ? h_cur : h_prev, h_cur);
                state_nx  = last_pair ? DONE : RD_O;
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            x_even    <= '0;
            x_odd     <= '0;
            x_next    <= '0;
            h_cur     <= '0;
            h_prev    <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state     <= state_nx;
            rd_addr_q <= rd_addr_c;
            wr_addr_q <= wr_addr_c;
            wr_data_q <= wr_data_c;
            case (state)
                IDLE: k <= '0;
                RD_O: if (k == '0) x_even <= rd_data;
                RD_E: x_odd <= rd_data;
                CALC: begin
                    x_next <= xn_sel;
                    h_cur  <= predict(x_odd, x_even, xn_sel);
                end
                WR_L: begin
                    h_prev <= h_cur;
                    x_even <= x_next;
                    if (!last_pair) k <= k_inc;
                end
                DONE: k <= '0;
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = done_c;
    assign rd_en   = rd_en_c;
    assign rd_addr = rd_addr_c;
    assign wr_en   = wr_en_c;
    assign wr_addr = wr_addr_c;
    assign wr_data = wr_data_c;

endmodule

// File: tb/tb_squash_row_ctrl.sv
// Scoreboard bench for squash_row_ctrl: one ROW_LEN=4 and one ROW_LEN=16 instance,
// each with a line-memory model; expected writes are queued and popped by a monitor.
module tb_squash_row_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ROW_LEN=4 instance
    logic       rst4, start4, busy4, done4, rd_en4, wr_en4;
    logic [1:0] rd_addr4, wr_addr4;
    logic [7:0] rd_data4 = '0, wr_data4;
    logic [7:0] mem4 [0:3];
    logic [9:0] q4 [$];

    // ROW_LEN=16 instance
    logic       rst16, start16, busy16, done16, rd_en16, wr_en16;
    logic [3:0] rd_addr16, wr_addr16;
    logic [7:0] rd_data16 = '0, wr_data16;
    logic [7:0] mem16 [0:15];
    logic [11:0] q16 [$];

    bit overlap = 1'b0;
    int max_rd16 = -1;

    squash_row_ctrl #(.ROW_LEN(4), .ADDR_W(2), .DATA_W(8)) u_dut4 (
        .clk(clk), .rst(rst4), .start(start4), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4)
    );

    squash_row_ctrl #(.ROW_LEN(16), .ADDR_W(4), .DATA_W(8)) u_dut16 (
        .clk(clk), .rst(rst16), .start(start16), .busy(busy16), .done(done16),
        .rd_en(rd_en16), .rd_addr(rd_addr16), .rd_data(rd_data16),
        .wr_en(wr_en16), .wr_addr(wr_addr16), .wr_data(wr_data16)
    );

    always @(posedge clk) begin
        if (rd_en4)  rd_data4  <= mem4[rd_addr4];
        if (rd_en16) rd_data16 <= mem16[rd_addr16];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops one expected {addr,data}
    always @(negedge clk) begin
        logic [9:0]  e4;
        logic [11:0] e16;
        if (wr_en4) begin
            n_cmp++;
            if (q4.size() == 0) begin
                n_bad++;
                $display("FAIL wr4_unexpected: got addr %0d data %0d expected no write", wr_addr4, wr_data4);
            end else begin
                e4 = q4.pop_front();
                if ({wr_addr4, wr_data4} !== e4) begin
                    n_bad++;
                    $display("FAIL wr4: got (%0d,%0d) expected (%0d,%0d)", wr_addr4, wr_data4, e4[9:8], e4[7:0]);
                end
            end
        end
        if (wr_en16) begin
            n_cmp++;
            if (q16.size() == 0) begin
                n_bad++;
                $display("FAIL wr16_unexpected: got addr %0d data %0d expected no write", wr_addr16, wr_data16);
            end else begin
                e16 = q16.pop_front();
                if ({wr_addr16, wr_data16} !== e16) begin
                    n_bad++;
                    $display("FAIL wr16: got (%0d,%0d) expected (%0d,%0d)", wr_addr16, wr_data16, e16[11:8], e16[7:0]);
                end
            end
        end
        if ((rd_en4 && wr_en4) || (rd_en16 && wr_en16)) overlap = 1'b1;
        if (rd_en16 && int'(rd_addr16) > max_rd16) max_rd16 = int'(rd_addr16);
    end

    // Directed ROW_LEN=4 row with hand-computed {addr,data} expectations
    task automatic run4(input logic [7:0] m0, m1, m2, m3,
                        input logic [9:0] e0, e1, e2, e3, input string tag);
        int cnt, ndone, done_at;
        mem4[0] = m0; mem4[1] = m1; mem4[2] = m2; mem4[3] = m3;
        q4.push_back(e0); q4.push_back(e1); q4.push_back(e2); q4.push_back(e3);
        chk({tag, "_idle"}, int'(busy4), 0);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cnt = 0; ndone = 0; done_at = 0;
        for (int c = 0; c < 100; c++) begin
            if (!busy4) break;
            cnt++;
            if (done4) begin ndone++; done_at = cnt; end
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, cnt, 12);
        chk({tag, "_done_at"}, done_at, 12);
        chk({tag, "_pending"}, q4.size(), 0);
    endtask

    // Formula model for ROW_LEN=16 pushes H[k],L[k] pairs in write order
    task automatic model16();
        int h [8];
        int xn, hl, l;
        for (int k = 0; k < 8; k++) begin
            xn = (k < 7) ? int'(mem16[2*k+2]) : int'(mem16[2*k]);
            h[k] = (int'(mem16[2*k+1]) - ((int'(mem16[2*k]) + xn) >> 1)) & 255;
        end
        for (int k = 0; k < 8; k++) begin
            hl = (k == 0) ? h[0] : h[k-1];
            l  = (int'(mem16[2*k]) + ((hl + h[k]) >> 2)) & 255;
            q16.push_back({4'(8 + k), 8'(h[k])});
            q16.push_back({4'(k), 8'(l)});
        end
    endtask

    task automatic run16(input bit inj, input bit abort, input string tag);
        int cnt, ndone, done_at;
        model16();
        chk({tag, "_idle"}, int'(busy16), 0);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        cnt = 0; ndone = 0; done_at = 0;
        for (int c = 0; c < 300; c++) begin
            if (!busy16) break;
            cnt++;
            if (done16) begin ndone++; done_at = cnt; end
            if (abort && cnt == 20) begin
                #1;
                chk({tag, "_wrh3_en"}, int'(wr_en16), 1);
                chk({tag, "_wrh3_addr"}, int'(wr_addr16), 11);
                rst16 = 1'b1;
                #1;
                chk({tag, "_async_zero"},
                    int'({rd_en16, rd_addr16, wr_en16, wr_addr16, wr_data16, busy16, done16}), 0);
                q16.delete();
                repeat (3) @(negedge clk);
                rst16 = 1'b0;
                repeat (5) @(negedge clk);
                chk({tag, "_idle_after_rst"}, int'(busy16), 0);
                return;
            end
            start16 = inj && (cnt == 5 || cnt == 20);
            @(negedge clk);
        end
        start16 = 1'b0;
        chk({tag, "_busy_cycles"}, cnt, 42);
        chk({tag, "_done_at"}, done_at, 42);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_pending"}, q16.size(), 0);
    endtask

    initial begin
        logic [7:0] row [16];
        row = '{22, 44, 50, 70, 76, 86, 54, 76, 88, 98, 42, 66, 66, 90, 86, 0};
        for (int i = 0; i < 16; i++) mem16[i] = row[i];
        rst4 = 1'b1; rst16 = 1'b1; start4 = 1'b0; start16 = 1'b0;
        #2;
        chk("reset4_zero", int'({busy4, done4, rd_en4, rd_addr4, wr_en4, wr_addr4, wr_data4}), 0);
        chk("reset16_zero", int'({busy16, done16, rd_en16, rd_addr16, wr_en16, wr_addr16, wr_data16}), 0);
        repeat (2) @(negedge clk);
        rst4 = 1'b0; rst16 = 1'b0;
        @(negedge clk);

        run4(8'd22, 8'd44, 8'd50, 8'd70,
             {2'd2, 8'd8}, {2'd0, 8'd26}, {2'd3, 8'd20}, {2'd1, 8'd57}, "r4_basic");
        @(negedge clk);
        run4(8'd0, 8'd255, 8'd0, 8'd255,
             {2'd2, 8'd255}, {2'd0, 8'd127}, {2'd3, 8'd255}, {2'd1, 8'd127}, "r4_carry");
        @(negedge clk);
        run4(8'd200, 8'd0, 8'd200, 8'd0,
             {2'd2, 8'd56}, {2'd0, 8'd228}, {2'd3, 8'd56}, {2'd1, 8'd228}, "r4_wrap");
        @(negedge clk);

        run16(1'b0, 1'b0, "r16_basic");
        @(negedge clk);
        run16(1'b1, 1'b0, "r16_ignored_start");
        run16(1'b0, 1'b0, "r16_back_to_back");
        @(negedge clk);
        run16(1'b0, 1'b1, "r16_abort");
        run16(1'b0, 1'b0, "r16_after_abort");
        repeat (3) @(negedge clk);

        chk("rd_wr_overlap", int'(overlap), 0);
        chk("max_rd_addr16", max_rd16, 15);
        chk("leftover_q4", q4.size(), 0);
        chk("leftover_q16", q16.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/squash_row_ctrl.md
Name: squash_row_ctrl

Overview:
Row sequencer for the 1-D lifting "squash" transform. It fetches one image row of ROW_LEN pixels from a line memory with 1-cycle read latency. For each even/odd pixel pair it runs the predict step (H) and the update step (L), with symmetric extension at both row edges. It writes the L band to the lower half of an output buffer and the H band to the upper half. It sits between the row line buffer and the coefficient buffer, and is started once per row by the frame-level controller.

Parameters:
- ROW_LEN, 16, pixels per row; must be even and >=4.
- ADDR_W, 4, address width; must satisfy 2^ADDR_W >= ROW_LEN.
- DATA_W, 8, pixel and coefficient width.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle request to process one row; sampled only in IDLE.
- busy, out, 1, high from the cycle after start is accepted through the DONE cycle inclusive.
- done, out, 1, one-cycle pulse when the last coefficient has been written.
- rd_en, out, 1, line-memory read strobe.
- rd_addr, out, ADDR_W, line-memory read address.
- rd_data, in, DATA_W, read data, valid the cycle after rd_en.
- wr_en, out, 1, coefficient-buffer write strobe.
- wr_addr, out, ADDR_W, write address: L[k] at k, H[k] at ROW_LEN/2+k.
- wr_data, out, DATA_W, coefficient value.

Behaviour:
- Reset (async): state=IDLE, pair index k=0. All outputs and internal registers (x_even, x_odd, x_next, h_cur, h_prev) are 0.
- Reset asserted mid-row: the row is abandoned immediately, with no further rd_en/wr_en. After release, the block waits in IDLE for a new start.
- Arithmetic, with M = ROW_LEN/2 pairs and k = 0..M-1:
  - H[k] = x[2k+1] - ((x[2k] + x[2k+2]) >> 1)
  - L[k] = x[2k] + ((H[k-1] + H[k]) >> 2)
  - Sums x+x and H+H are formed at DATA_W+1 bits, unsigned, before the shift. The final subtract and add are truncated mod 2^DATA_W (wrap, no saturation).
  - Edge extension: x[ROW_LEN] = x[ROW_LEN-2], i.e. for k=M-1, x_next = x_even. H[-1] = H[0].
- FSM states: IDLE, RD0, RD_O, RD_E, CALC, WR_H, WR_L, DONE.
  - IDLE: outputs idle. start=1 -> RD0. Start in any other state is ignored, with no queuing.
  - RD0: rd_en=1, rd_addr=0 -> RD_O.
  - RD_O: rd_en=1, rd_addr=2k+1. If k==0, capture x_even <= rd_data. -> RD_E.
  - RD_E: capture x_odd <= rd_data. If k<M-1: rd_en=1, rd_addr=2k+2. Else no read. -> CALC.
  - CALC: x_next <= (k<M-1) ? rd_data : x_even. Compute h_cur. -> WR_H.
  - WR_H: wr_en=1, wr_addr=M+k, wr_data=h_cur. -> WR_L.
  - WR_L: wr_en=1, wr_addr=k, wr_data=L[k], using h_prev when k>0 and h_cur when k==0. Then h_prev <= h_cur and x_even <= x_next. If k==M-1 -> DONE, else k <= k+1 -> RD_O.
  - DONE: done=1 for one cycle, wr_en=0 -> IDLE.
- rd_en and wr_en are never high in the same cycle. rd_en is low in every state not listed above.
- Latency: start sampled at edge E0; busy is high for exactly 2 + 5*M cycles; done is high in the last of those cycles. For ROW_LEN=16 this is 42 cycles.
- Write order per pair is H[k] then L[k]; k is strictly ascending. Each output address is written exactly once per row.
- A new start is accepted in the first IDLE cycle after DONE (back-to-back rows, 1 idle cycle).
- rd_addr, wr_addr, and wr_data hold their last value when their strobe is low. Checkers must qualify them with the strobe.

Test Plan:
- ROW_LEN=4, memory {22,44,50,70}, pulse start -> writes in order (2,8), (0,26), (3,20), (1,57); then done; busy high for 12 cycles.
- ROW_LEN=4, memory {0,255,0,255} -> H0=255, H1=255; L0=127 and L1=0+((255+255)>>2)=127, proving the 9-bit intermediate sums. Writes go to (2,255), (0,127), (3,255), (1,127).
- ROW_LEN=4, memory {200,0,200,0} -> H0=H1=56 (wrap); L0=L1=228. Confirms mod-256 subtraction.
- ROW_LEN=16, memory {22,44,50,70,76,86,54,76,88,98,42,66,66,90,86,0} -> compare all 16 writes against the formula model. rd_addr never exceeds 15; address 15 is read and 16 is never requested. done lands at cycle 42.
- Start pulsed again at cycles 5 and 20 of a running row -> ignored; exactly one done. A start in the cycle after done -> second row starts, identical result.
- Assert rst during WR_H of pair 3 (ROW_LEN=16) -> all outputs 0 asynchronously, no further writes. A later start produces the full correct row.
